// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared register-id constants and the writeback entry type
package wb_arbiter_pkg;
    localparam int REG_ID_W = 5;
    localparam logic [REG_ID_W-1:0] REG_ZERO = '0;
    localparam int WB_XLEN = 32;
    typedef struct packed {
        logic [REG_ID_W-1:0] rd;
        logic [WB_XLEN-1:0]  data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular buffer of load results, entries exposed oldest-first for lookup
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int W     = REG_ID_W + WB_XLEN,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [$clog2(DEPTH):0] count,
    output logic [W-1:0]           age_data [DEPTH],
    output logic [DEPTH-1:0]       age_valid
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    // pointers wrap naturally since DEPTH is a power of two; count separates full from empty
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // storage needs no reset: only slots marked valid are ever observed
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // re-index storage by age so slot 0 is the head and higher slots are younger
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_data[i]  = mem[rd_ptr + PW'(i)];
            age_valid[i] = CW'(i) < count;
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU and buffered load results onto the register-file write port
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [REG_ID_W-1:0]    alu_rd,
    input  logic [XLEN-1:0]        alu_data,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [REG_ID_W-1:0]    ld_rd,
    input  logic [XLEN-1:0]        ld_data,
    output logic                   wb_wr_en,
    output logic [REG_ID_W-1:0]    wb_wr_id,
    output logic [XLEN-1:0]        wb_wr_data,
    input  logic [REG_ID_W-1:0]    q_id,
    output logic                   q_hit,
    output logic [XLEN-1:0]        q_data,
    output logic [$clog2(DEPTH):0] ld_count
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = REG_ID_W + XLEN;

    logic             full;
    logic             push;
    logic             pop;
    logic             alu_win;
    logic             grant;
    logic [EW-1:0]    sel;
    logic [EW-1:0]    age_data [DEPTH];
    logic [DEPTH-1:0] age_valid;

    // a full FIFO locks out the ALU so loads always make progress
    assign full      = ld_count == CW'(DEPTH);
    assign ld_ready  = !full;
    assign alu_ready = !full;
    assign push      = ld_valid && !full;
    assign alu_win   = alu_valid && !full;
    assign pop       = !alu_win && (ld_count != '0);
    assign grant     = alu_win || pop;
    assign sel       = alu_win ? {alu_rd, alu_data} : age_data[0];

    wb_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .n_rst     (n_rst),
        .push      (push),
        .push_data ({ld_rd, ld_data}),
        .pop       (pop),
        .count     (ld_count),
        .age_data  (age_data),
        .age_valid (age_valid)
    );

    // single write stage; x0 results are consumed without raising the enable
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wb_wr_en   <= 1'b0;
            wb_wr_id   <= '0;
            wb_wr_data <= '0;
        end else begin
            wb_wr_en <= grant && (sel[EW-1 -: REG_ID_W] != REG_ZERO);
            if (grant) {wb_wr_id, wb_wr_data} <= sel;
        end
    end

    // youngest pending value wins: output register first, then FIFO head-to-tail overrides
    always_comb begin
        q_hit  = 1'b0;
        q_data = '0;
        if (wb_wr_en && wb_wr_id == q_id) begin
            q_hit  = 1'b1;
            q_data = wb_wr_data;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (age_valid[i] && age_data[i][EW-1 -: REG_ID_W] == q_id) begin
                q_hit  = 1'b1;
                q_data = age_data[i][XLEN-1:0];
            end
        end
        if (q_id == REG_ZERO) begin
            q_hit  = 1'b0;
            q_data = '0;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and random checks of wb_arbiter against a queue-based model
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        alu_valid, alu_ready, ld_valid, ld_ready;
    logic [4:0]  alu_rd, ld_rd, wb_wr_id, q_id;
    logic [31:0] alu_data, ld_data, wb_wr_data, q_data;
    logic        wb_wr_en, q_hit;
    logic [2:0]  ld_count;

    int n_checks = 0;
    int n_fail   = 0;

    wb_entry_t   mq[$];
    logic        m_en;
    logic [4:0]  m_id;
    logic [31:0] m_data;

    wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .wb_wr_en   (wb_wr_en),
        .wb_wr_id   (wb_wr_id),
        .wb_wr_data (wb_wr_data),
        .q_id       (q_id),
        .q_hit      (q_hit),
        .q_data     (q_data),
        .ld_count   (ld_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_en   = 1'b0;
        m_id   = '0;
        m_data = '0;
    endtask

    // compare every observable output against the model
    task automatic check_model();
        int   n;
        logic eh;
        logic [31:0] ed;
        n  = mq.size();
        eh = 1'b0;
        ed = '0;
        chk("wb_wr_en", wb_wr_en, m_en);
        if (m_en) begin
            chk("wb_wr_id", wb_wr_id, m_id);
            chk("wb_wr_data", wb_wr_data, m_data);
        end
        chk("ld_count", ld_count, n);
        chk("ld_ready", ld_ready, n < DEPTH);
        chk("alu_ready", alu_ready, n < DEPTH);
        if (q_id != 0) begin
            for (int i = n - 1; i >= 0; i--) begin
                if (!eh && mq[i].rd == q_id) begin
                    eh = 1'b1;
                    ed = mq[i].data;
                end
            end
            if (!eh && m_en && m_id == q_id) begin
                eh = 1'b1;
                ed = m_data;
            end
        end
        chk("q_hit", q_hit, eh);
        chk("q_data", q_data, ed);
    endtask

    // one clock of arbitration rules: full FIFO wins, else ALU, else any buffered load
    task automatic model_update();
        logic      full, take_ld, grant;
        wb_entry_t g;
        full    = mq.size() == DEPTH;
        take_ld = full || (!alu_valid && mq.size() != 0);
        grant   = take_ld || alu_valid;
        if (take_ld) g = mq.pop_front();
        else g = '{rd: alu_rd, data: alu_data};
        if (ld_valid && !full) mq.push_back('{rd: ld_rd, data: ld_data});
        m_en = grant && g.rd != 0;
        if (grant) begin
            m_id   = g.rd;
            m_data = g.data;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_model();
        @(posedge clk);
        if (n_rst) model_update();
        #1;
    endtask

    task automatic idle();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_valid  = 0; ld_rd  = 0; ld_data  = 0;
    endtask

    initial begin
        n_rst = 1'b0;
        q_id  = 0;
        idle();
        model_clear();
        #12;
        chk("rst wb_wr_en", wb_wr_en, 0);
        chk("rst wb_wr_id", wb_wr_id, 0);
        chk("rst wb_wr_data", wb_wr_data, 0);
        chk("rst ld_count", ld_count, 0);
        chk("rst ld_ready", ld_ready, 1);
        chk("rst alu_ready", alu_ready, 1);
        chk("rst q_hit", q_hit, 0);
        chk("rst q_data", q_data, 0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        step();

        // ALU only
        alu_valid = 1; alu_rd = 5; alu_data = 32'h11;
        #1 chk("alu only ready", alu_ready, 1);
        step();
        chk("alu only en", wb_wr_en, 1);
        chk("alu only id", wb_wr_id, 5);
        chk("alu only data", wb_wr_data, 32'h11);
        idle();
        step();

        // loads fill while ALU is held busy
        for (int i = 1; i <= 4; i++) begin
            alu_valid = 1; alu_rd = 9; alu_data = 32'h900 + i;
            ld_valid = 1; ld_rd = 5'(i); ld_data = 32'hA0 + i;
            step();
        end
        ld_valid = 0;
        #1;
        chk("fill count", ld_count, 4);
        chk("fill ld_ready", ld_ready, 0);
        chk("fill alu_ready", alu_ready, 0);
        step();
        chk("fill first id", wb_wr_id, 1);
        chk("fill first data", wb_wr_data, 32'hA1);
        #1 chk("post pop alu_ready", alu_ready, 1);
        step();
        chk("alu resumes id", wb_wr_id, 9);
        idle();
        repeat (4) step();

        // rd 0 is consumed silently
        alu_valid = 1; alu_rd = 0; alu_data = 32'hFF;
        step();
        chk("rd0 en", wb_wr_en, 0);
        alu_rd = 3; alu_data = 32'h33;
        step();
        chk("rd3 en", wb_wr_en, 1);
        chk("rd3 id", wb_wr_id, 3);
        idle();
        step();

        // lookup: FIFO 7:10 head, 7:20 tail, output register 7:30
        alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
        ld_valid = 1; ld_rd = 7; ld_data = 32'h10;
        step();
        ld_data = 32'h20;
        step();
        ld_valid = 0; alu_rd = 7; alu_data = 32'h30;
        step();
        idle();
        q_id = 7;
        #1;
        chk("lookup hit", q_hit, 1);
        chk("lookup data", q_data, 32'h20);
        q_id = 0;
        #1;
        chk("lookup x0 hit", q_hit, 0);
        chk("lookup x0 data", q_data, 0);
        q_id = 9;
        #1 chk("lookup miss", q_hit, 0);
        q_id = 12;

        // simultaneous push and pop at count 2
        ld_valid = 1; ld_rd = 12; ld_data = 32'h77;
        step();
        chk("pushpop count", ld_count, 2);
        chk("pushpop id", wb_wr_id, 7);
        chk("pushpop data", wb_wr_data, 32'h10);
        chk("pushpop tail hit", q_hit, 1);
        chk("pushpop tail data", q_data, 32'h77);

        // reset mid-stream with three buffered entries and a pending write
        alu_valid = 1; alu_rd = 4; alu_data = 32'h44;
        ld_valid = 1; ld_rd = 13; ld_data = 32'h88;
        step();
        chk("pre-rst count", ld_count, 3);
        chk("pre-rst en", wb_wr_en, 1);
        n_rst = 1'b0;
        idle();
        model_clear();
        #1;
        chk("mid-rst en", wb_wr_en, 0);
        chk("mid-rst count", ld_count, 0);
        chk("mid-rst ld_ready", ld_ready, 1);
        chk("mid-rst q_hit", q_hit, 0);
        step();
        step();
        n_rst = 1'b1;
        repeat (3) step();
        chk("post-rst en", wb_wr_en, 0);

        // random traffic, periodically letting the ALU go quiet so the FIFO drains
        for (int c = 0; c < 3000; c++) begin
            alu_valid = ((c / 200) % 3 == 2) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 6);
            alu_rd    = 5'($urandom_range(0, 7));
            alu_data  = $urandom;
            ld_valid  = $urandom_range(0, 1) == 1;
            ld_rd     = 5'($urandom_range(0, 7));
            ld_data   = $urandom;
            q_id      = 5'($urandom_range(0, 7));
            step();
        end
        idle();
        repeat (6) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
